// File: rtl/rhd_chip_emulator.sv
`default_nettype none
// ============================================================================
// Module   : rhd_chip_emulator
// Purpose  : Responder-side model of one RHD2164 MISO lane. It decodes the
//            16-bit SPI command stream (CONVERT, CALIBRATE, CLEAR, WRITE and
//            READ) and returns each result two frames later, as the real chip
//            does.
// Options  : RHD_EMU_FRAME_ERR_EN adds the frame_err pulse and the saturating
//            frame_err_count outputs for discarded frames.
// Revision : 1.0 - initial release
// ============================================================================
module rhd_chip_emulator #(
    parameter int STARTING_SEED = 0,
    parameter int NUM_CHANNELS  = 64,
    parameter int CHIP_ID       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        cmd_strobe,
    output logic [15:0] cmd_word,
`ifdef RHD_EMU_FRAME_ERR_EN
    output logic        frame_err,
    output logic [7:0]  frame_err_count,
`endif
    output logic [15:0] conv_count
);

    localparam logic [15:0] C_SEED      = 16'(STARTING_SEED);
    localparam logic [15:0] C_NCH       = 16'(NUM_CHANNELS);
    localparam logic [15:0] C_LAST_CH   = 16'(NUM_CHANNELS - 1);
    localparam logic [7:0]  C_NCH8      = 8'(NUM_CHANNELS);
    localparam logic [7:0]  C_CHIP_ID   = 8'(CHIP_ID);
    localparam int          C_NUM_RW    = 22;
    localparam logic [15:0] C_CMD_CLEAR = 16'h6A00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    // Synchronizer and edge-detect flops (never reset: they must keep tracking
    // the pins while rst is high so the post-reset state reflects CS).
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_shift_q, rx_shift_d;
    logic [15:0] tx_shift_q, tx_shift_d;
    logic        miso_q, miso_d;
    logic [15:0] stage_a_q, stage_a_d;
    logic [15:0] stage_b_q, stage_b_d;
    logic [15:0] cmd_word_q, cmd_word_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [15:0] conv_count_q, conv_count_d;
    logic [7:0]  regs_q [0:C_NUM_RW-1];
    logic [7:0]  regs_d [0:C_NUM_RW-1];

`ifdef RHD_EMU_FRAME_ERR_EN
    logic        discard;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  frame_err_count_q, frame_err_count_d;
`endif

    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [3:0]  tx_idx;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  rd_data;
    logic [15:0] result;

    // Two-flop synchronizers on all three SPI pins plus one flop for edges.
    always_ff @(posedge clk) begin
        sclk_meta_q <= SCLK;
        sclk_sync_q <= sclk_meta_q;
        sclk_prev_q <= sclk_sync_q;
        mosi_meta_q <= MOSI;
        mosi_sync_q <= mosi_meta_q;
        cs_meta_q   <= CS;
        cs_sync_q   <= cs_meta_q;
        cs_prev_q   <= cs_sync_q;
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q & cs_prev_q;

    // After k rising edges the master expects bit (15-k) of the result.
    assign tx_idx    = 4'(5'd15 - bit_cnt_q);
    assign cmd_addr  = rx_shift_q[13:8];
    assign cmd_data  = rx_shift_q[7:0];

    // Register file read port: R/W bank, identification ROM, zeros elsewhere.
    always_comb begin
        rd_data = 8'h00;
        if (cmd_addr < 6'(C_NUM_RW)) begin
            rd_data = regs_q[cmd_addr[4:0]];
        end else begin
            case (cmd_addr)
                6'd40:   rd_data = 8'h49;
                6'd41:   rd_data = 8'h4E;
                6'd42:   rd_data = 8'h54;
                6'd43:   rd_data = 8'h41;
                6'd44:   rd_data = 8'h4E;
                6'd60:   rd_data = 8'h01;
                6'd61:   rd_data = 8'h00;
                6'd62:   rd_data = C_NCH8;
                6'd63:   rd_data = C_CHIP_ID;
                default: rd_data = 8'h00;
            endcase
        end
    end

    // Frame FSM next state, shift registers, command decode and pipeline.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        stage_a_d    = stage_a_q;
        stage_b_d    = stage_b_q;
        cmd_word_d   = cmd_word_q;
        cmd_strobe_d = 1'b0;
        conv_count_d = conv_count_q;
        regs_d       = regs_q;
        result       = 16'h0000;
`ifdef RHD_EMU_FRAME_ERR_EN
        discard      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = 5'd0;
                    tx_shift_d = stage_b_q;
                    miso_d     = stage_b_q[15];
                end
            end
            ST_SHIFT: begin
                // CS rising wins over any SCLK edge seen in the same cycle.
                if (cs_rise) begin
                    miso_d = 1'b0;
                    if (bit_cnt_q == 5'd16) begin
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_IDLE;
`ifdef RHD_EMU_FRAME_ERR_EN
                        discard = 1'b1;
`endif
                    end
                end else if (sclk_rise) begin
                    if (bit_cnt_q == 5'd16) begin
                        state_d = ST_ABORT;
                        miso_d  = 1'b0;
`ifdef RHD_EMU_FRAME_ERR_EN
                        discard = 1'b1;
`endif
                    end else begin
                        rx_shift_d = {rx_shift_q[14:0], mosi_sync_q};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 5'd16) begin
                        miso_d = 1'b0;
                    end else if (bit_cnt_q != 5'd0) begin
                        miso_d = tx_shift_q[tx_idx];
                    end
                end
            end
            ST_DECODE: begin
                // CALIBRATE and unknown 01-class words simply return zero.
                case (rx_shift_q[15:14])
                    2'b00: begin
                        if ({10'd0, cmd_addr} < C_NCH) begin
                            result = C_SEED + {10'd0, cmd_addr} + conv_count_q;
                            if ({10'd0, cmd_addr} == C_LAST_CH) begin
                                conv_count_d = conv_count_q + 16'd1;
                            end
                        end
                    end
                    2'b01: begin
                        if (rx_shift_q == C_CMD_CLEAR) begin
                            conv_count_d = 16'h0000;
                        end
                    end
                    2'b10: begin
                        result = {8'hFF, cmd_data};
                        if (cmd_addr < 6'(C_NUM_RW)) begin
                            regs_d[cmd_addr[4:0]] = cmd_data;
                        end
                    end
                    default: begin
                        result = {8'h00, rd_data};
                    end
                endcase
                stage_b_d    = stage_a_q;
                stage_a_d    = result;
                cmd_word_d   = rx_shift_q;
                cmd_strobe_d = 1'b1;
                miso_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                miso_d = 1'b0;
                if (cs_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

`ifdef RHD_EMU_FRAME_ERR_EN
    // Discard pulse and saturating discard counter.
    always_comb begin
        frame_err_d       = discard;
        frame_err_count_d = frame_err_count_q;
        if (discard && (frame_err_count_q != 8'hFF)) begin
            frame_err_count_d = frame_err_count_q + 8'd1;
        end
    end

    // Discard status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q       <= 1'b0;
            frame_err_count_q <= 8'h00;
        end else begin
            frame_err_q       <= frame_err_d;
            frame_err_count_q <= frame_err_count_d;
        end
    end

    assign frame_err       = frame_err_q;
    assign frame_err_count = frame_err_count_q;
`endif

    // State register; a reset released with CS low lands in ABORT so the
    // interrupted frame can never be decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= cs_sync_q ? ST_IDLE : ST_ABORT;
            bit_cnt_q    <= 5'd0;
            rx_shift_q   <= 16'h0000;
            tx_shift_q   <= 16'h0000;
            miso_q       <= 1'b0;
            stage_a_q    <= 16'h0000;
            stage_b_q    <= 16'h0000;
            cmd_word_q   <= 16'h0000;
            cmd_strobe_q <= 1'b0;
            conv_count_q <= 16'h0000;
            for (int i = 0; i < C_NUM_RW; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            stage_a_q    <= stage_a_d;
            stage_b_q    <= stage_b_d;
            cmd_word_q   <= cmd_word_d;
            cmd_strobe_q <= cmd_strobe_d;
            conv_count_q <= conv_count_d;
            regs_q       <= regs_d;
        end
    end

    assign MISO       = miso_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_word   = cmd_word_q;
    assign conv_count = conv_count_q;

endmodule
`default_nettype wire
